mul_err_monitor: RTL and testbench
==================================

# mul_err_monitor

Streaming error-statistics collector placed directly downstream of the approximate Dadda multiplier. It accepts operand pairs together with the multiplier's approximate product under a valid/ready handshake, computes the exact product internally and measures the absolute error distance (ED). Over a run of a programmed number of samples it accumulates sample count, erroneous-sample count, ED sum and maximum ED. It is the hardware counterpart of the software error-characterisation flow for each approximate full-adder variant.

## Interface
- WIDTH, 8: operand width; it must match the multiplier's WIDTH.
- NSAMP_W, 16: width of the sample and error counters and of num_samples.
- SUM_W, 40: width of the ED accumulator.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- start  in  1  single-cycle pulse that clears the statistics and begins a run.
- num_samples  in  NSAMP_W  run length; latched on an accepted start.
- in_valid  in  1  operand/product pair is valid.
- in_ready  out  1  monitor accepts the pair this cycle.
- in1, in2  in  WIDTH  operands applied to the multiplier.
- approx  in  2*WIDTH+1  multiplier output `out`.
- busy  out  1  asserted in RUN or DRAIN.
- done  out  1  level; asserted in DONE.
- sample_cnt  out  NSAMP_W  number of samples accumulated.
- err_cnt  out  NSAMP_W  number of samples with ED≠0.
- ed_sum  out  SUM_W  sum of ED; saturates at all-ones.
- ed_max  out  2*WIDTH+1  largest ED seen.
- max_in1, max_in2  out  WIDTH  operands of the first sample that reached ed_max. These ports exist only under MUL_ERR_ARGMAX_EN.

## Operation
- States are IDLE, RUN, DRAIN and DONE. The state encoding and every output reset to 0; the reset state is IDLE.
- start is honoured only in IDLE or DONE. An honoured start clears all statistics, latches num_samples and clears the accept counter.
  - If num_samples≠0, the next state is RUN.
  - If num_samples=0, the next state is DONE with zero statistics.
- start is ignored in RUN and DRAIN.
- in_ready = (state==RUN) && (accepted < num_samples). A handshake is in_valid && in_ready.
- RUN moves to DRAIN on the edge of the last handshake.
- DRAIN moves to DONE on the edge where the last sample updates the accumulators.
- Pipeline:
  - S1 registers in1, in2, approx and a valid bit.
  - S2 computes exact = in1*in2, zero-extends it to 2*WIDTH+1 bits, and registers ED = |exact − approx|.
  - The accumulate stage adds ED to ed_sum and increments sample_cnt. It increments err_cnt when ED≠0 and updates ed_max when ED > ed_max (strictly greater).
- ed_sum saturates and never wraps. The counters cannot overflow because the accept count is bounded by num_samples.
- A start together with in_valid in IDLE or DONE does not capture that pair, because in_ready is 0 that cycle.
- Asserting rst_n low mid-run immediately returns every register to its reset value. Samples in flight are discarded.

## Timing
- Handshake on edge E: the sample is in S1 after E, in S2 after E+1, and reflected in the statistics outputs after E+2.
- Last handshake on edge E: done is visible after E+2, in the same cycle the final statistics are visible.
- Full throughput: one sample per cycle with no bubbles.
- in_ready falls in the cycle after the last handshake. It stays 0 through DRAIN and DONE.
- Statistics outputs are registered and stable from done until the next honoured start. They clear on the edge after that start.

## Configuration
- MUL_ERR_ARGMAX_EN defined:
  - max_in1 and max_in2 are present.
  - Both load with the S2 operands whenever ed_max updates.
  - Both clear on start and on reset.
- MUL_ERR_ARGMAX_EN undefined: the ports and their registers are absent. All other behaviour is identical.

## Structure
- Package mul_err_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - a function ed_w(WIDTH) returning 2*WIDTH+1;
  - the default SUM_W constant.
- Sub-module mul_err_acc holds the accumulate stage: the saturating ed_sum, err_cnt, ed_max and the argmax registers, with clear and enable inputs.
- The top module holds the FSM, the accept counter and S1/S2.

## Test plan
- Reset:
  - Stimulus: drive rst_n low at any time.
  - Response: every output is 0, in_ready=0 and busy=0. The reset is asynchronous, so a mid-cycle assertion clears outputs without waiting for clk.
- Exact sample:
  - Stimulus: start with num_samples=1, then in1=3, in2=5, approx=15.
  - Response: after 3 edges, done=1, sample_cnt=1, err_cnt=0, ed_sum=0, ed_max=0.
- Mixed run:
  - Stimulus: num_samples=3 with pairs (255,255,approx 65000), (10,10,approx 110) and (0,7,approx 0).
  - Response: sample_cnt=3, err_cnt=2, ed_sum=35, ed_max=25. Under the macro, max_in1=255 and max_in2=255.
- Over-estimate and backpressure:
  - Stimulus: num_samples=2 with pairs (3,5,approx 20) and (2,2,approx 4). Keep in_valid high for a third pair.
  - Response: ed_sum=5 and sample_cnt=2. in_ready=0 after the second accept, so the third pair is not counted.
- Control corner cases:
  - Stimulus: start during RUN; start with num_samples=0; start in DONE.
  - Response: start in RUN is ignored and the counts are unchanged. num_samples=0 gives done one cycle after start with zero statistics. start in DONE clears the statistics and re-enters RUN.
- Reset mid-run:
  - Stimulus: pulse rst_n low during RUN with samples in flight.
  - Response: IDLE with all statistics 0. The next start with num_samples=1 and pair (1,1,approx 1) yields sample_cnt=1.

Source files
------------

// File: rtl/mul_err_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
package mul_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SUM_W_DEF = 40;

  // Error distance spans the zero-extended product plus the multiplier's carry-out bit.
  function automatic int ed_w(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/mul_err_acc.sv
// Accumulate stage: saturating ED sum, sample/error counters and running max ED.
// Argmax operand registers exist only when MUL_ERR_ARGMAX_EN is defined.
module mul_err_acc
  import mul_err_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NSAMP_W = 16,
  parameter int SUM_W   = SUM_W_DEF,
  localparam int ED_W   = ed_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               en,
  input  logic [ED_W-1:0]    ed,
`ifdef MUL_ERR_ARGMAX_EN
  input  logic [WIDTH-1:0]   op_in1,
  input  logic [WIDTH-1:0]   op_in2,
  output logic [WIDTH-1:0]   max_in1,
  output logic [WIDTH-1:0]   max_in2,
`endif
  output logic [NSAMP_W-1:0] sample_cnt,
  output logic [NSAMP_W-1:0] err_cnt,
  output logic [SUM_W-1:0]   ed_sum,
  output logic [ED_W-1:0]    ed_max
);

  logic [SUM_W:0] sum_ext;
  logic           ed_is_max;

  // One extra bit catches the carry so the sum can pin at all-ones instead of wrapping.
  assign sum_ext   = {1'b0, ed_sum} + (SUM_W + 1)'(ed);
  assign ed_is_max = ed > ed_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else if (clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      ed_sum     <= '0;
      ed_max     <= '0;
    end else if (en) begin
      sample_cnt <= sample_cnt + NSAMP_W'(1);
      if (ed != '0) err_cnt <= err_cnt + NSAMP_W'(1);
      ed_sum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      if (ed_is_max) ed_max <= ed;
    end
  end

`ifdef MUL_ERR_ARGMAX_EN
  // Strict comparison keeps the operands of the first sample to reach the max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_in1 <= '0;
      max_in2 <= '0;
    end else if (clear) begin
      max_in1 <= '0;
      max_in2 <= '0;
    end else if (en && ed_is_max) begin
      max_in1 <= op_in1;
      max_in2 <= op_in2;
    end
  end
`endif

endmodule

// File: rtl/mul_err_monitor.sv
// Streaming error-statistics collector for the approximate Dadda multiplier.
// Optional argmax outputs (max_in1/max_in2) are enabled by defining MUL_ERR_ARGMAX_EN.
module mul_err_monitor
  import mul_err_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NSAMP_W = 16,
  parameter int SUM_W   = SUM_W_DEF,
  localparam int ED_W   = ed_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NSAMP_W-1:0] num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [ED_W-1:0]    approx,
  output logic               busy,
  output logic               done,
  output logic [NSAMP_W-1:0] sample_cnt,
  output logic [NSAMP_W-1:0] err_cnt,
  output logic [SUM_W-1:0]   ed_sum,
  output logic [ED_W-1:0]    ed_max
`ifdef MUL_ERR_ARGMAX_EN
  ,
  output logic [WIDTH-1:0]   max_in1,
  output logic [WIDTH-1:0]   max_in2
`endif
);

  state_t             state, state_next;
  logic [NSAMP_W-1:0] accepted;
  logic [NSAMP_W-1:0] n_lat;
  logic               start_ok;
  logic               hs;
  logic               last_hs;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_in1, s1_in2;
  logic [ED_W-1:0]    s1_approx;
  logic               s2_valid;
  logic [ED_W-1:0]    s2_ed;
`ifdef MUL_ERR_ARGMAX_EN
  logic [WIDTH-1:0]   s2_in1, s2_in2;
`endif

  logic [2*WIDTH-1:0] exact;
  logic [ED_W-1:0]    exact_ext;
  logic [ED_W-1:0]    ed_calc;

  assign start_ok = start && (state == IDLE || state == DONE);
  assign in_ready = (state == RUN) && (accepted < n_lat);
  assign hs       = in_valid && in_ready;
  assign last_hs  = hs && ((accepted + NSAMP_W'(1)) == n_lat);
  assign busy     = (state == RUN) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // In DRAIN no new samples enter, so S2 holding data with S1 empty means the last sample.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = (num_samples == '0) ? DONE : RUN;
      RUN:        if (last_hs) state_next = DRAIN;
      DRAIN:      if (s2_valid && !s1_valid) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted <= '0;
      n_lat    <= '0;
    end else if (start_ok) begin
      accepted <= '0;
      n_lat    <= num_samples;
    end else if (hs) begin
      accepted <= accepted + NSAMP_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_in1    <= '0;
      s1_in2    <= '0;
      s1_approx <= '0;
    end else begin
      s1_valid <= hs && !start_ok;
      if (hs) begin
        s1_in1    <= in1;
        s1_in2    <= in2;
        s1_approx <= approx;
      end
    end
  end

  assign exact     = {{WIDTH{1'b0}}, s1_in1} * {{WIDTH{1'b0}}, s1_in2};
  assign exact_ext = {1'b0, exact};
  assign ed_calc   = (exact_ext >= s1_approx) ? (exact_ext - s1_approx)
                                              : (s1_approx - exact_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_ed    <= '0;
    end else begin
      s2_valid <= s1_valid && !start_ok;
      if (s1_valid) s2_ed <= ed_calc;
    end
  end

`ifdef MUL_ERR_ARGMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_in1 <= '0;
      s2_in2 <= '0;
    end else if (s1_valid) begin
      s2_in1 <= s1_in1;
      s2_in2 <= s1_in2;
    end
  end
`endif

  mul_err_acc #(
    .WIDTH   (WIDTH),
    .NSAMP_W (NSAMP_W),
    .SUM_W   (SUM_W)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .en         (s2_valid),
    .ed         (s2_ed),
`ifdef MUL_ERR_ARGMAX_EN
    .op_in1     (s2_in1),
    .op_in2     (s2_in2),
    .max_in1    (max_in1),
    .max_in2    (max_in2),
`endif
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .ed_sum     (ed_sum),
    .ed_max     (ed_max)
  );

endmodule

// File: tb/tb_mul_err_monitor.sv
// Directed plus randomized bench for mul_err_monitor against a list-based error model.
// Argmax outputs are connected and checked when MUL_ERR_ARGMAX_EN is defined.
module tb_mul_err_monitor;

  localparam int WIDTH   = 8;
  localparam int NSAMP_W = 16;
  localparam int SUM_W   = 40;
  localparam int ED_W    = 2 * WIDTH + 1;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [NSAMP_W-1:0] num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in1, in2;
  logic [ED_W-1:0]    approx;
  logic               busy, done;
  logic [NSAMP_W-1:0] sample_cnt, err_cnt;
  logic [SUM_W-1:0]   ed_sum;
  logic [ED_W-1:0]    ed_max;
`ifdef MUL_ERR_ARGMAX_EN
  logic [WIDTH-1:0]   max_in1, max_in2;
`endif

  int total = 0;
  int bad   = 0;
  int qa[$], qb[$], qx[$];

  mul_err_monitor #(.WIDTH(WIDTH), .NSAMP_W(NSAMP_W), .SUM_W(SUM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in1         (in1),
    .in2         (in2),
    .approx      (approx),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .ed_sum      (ed_sum),
    .ed_max      (ed_max)
`ifdef MUL_ERR_ARGMAX_EN
    ,
    .max_in1     (max_in1),
    .max_in2     (max_in2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: statistics recomputed from the whole list of accepted pairs.
  task automatic checkStats(input string tag);
    longint cnt = 0, err = 0, sum = 0, mx = 0, ex, ed;
`ifdef MUL_ERR_ARGMAX_EN
    int ma = 0, mb = 0;
`endif
    foreach (qa[i]) begin
      ex = longint'(qa[i]) * longint'(qb[i]);
      ed = (ex >= longint'(qx[i])) ? ex - longint'(qx[i]) : longint'(qx[i]) - ex;
      cnt++;
      if (ed != 0) err++;
      sum += ed;
      if (ed > mx) begin
        mx = ed;
`ifdef MUL_ERR_ARGMAX_EN
        ma = qa[i];
        mb = qb[i];
`endif
      end
    end
    checkOutput({tag, ".sample_cnt"}, 64'(sample_cnt), 64'(cnt));
    checkOutput({tag, ".err_cnt"},    64'(err_cnt),    64'(err));
    checkOutput({tag, ".ed_sum"},     64'(ed_sum),     64'(sum));
    checkOutput({tag, ".ed_max"},     64'(ed_max),     64'(mx));
`ifdef MUL_ERR_ARGMAX_EN
    checkOutput({tag, ".max_in1"},    64'(max_in1),    64'(ma));
    checkOutput({tag, ".max_in2"},    64'(max_in2),    64'(mb));
`endif
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".busy"},       64'(busy),       64'(0));
    checkOutput({tag, ".done"},       64'(done),       64'(0));
    checkOutput({tag, ".in_ready"},   64'(in_ready),   64'(0));
    checkOutput({tag, ".sample_cnt"}, 64'(sample_cnt), 64'(0));
    checkOutput({tag, ".err_cnt"},    64'(err_cnt),    64'(0));
    checkOutput({tag, ".ed_sum"},     64'(ed_sum),     64'(0));
    checkOutput({tag, ".ed_max"},     64'(ed_max),     64'(0));
`ifdef MUL_ERR_ARGMAX_EN
    checkOutput({tag, ".max_in1"},    64'(max_in1),    64'(0));
    checkOutput({tag, ".max_in2"},    64'(max_in2),    64'(0));
`endif
  endtask

  task automatic doStart(input int n);
    start       = 1'b1;
    num_samples = NSAMP_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feed pairs [first,last) from the queues; the bench predicts in_ready from its own count.
  task automatic applyStimulus(input int first, input int last, input bit gaps);
    int acc    = first;
    int cycles = 0;
    bit v;
    while (acc < last) begin
      checkOutput("run.in_ready", 64'(in_ready), 64'(1));
      v        = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid = v;
      if (v) begin
        in1    = WIDTH'(qa[acc]);
        in2    = WIDTH'(qb[acc]);
        approx = ED_W'(qx[acc]);
      end else begin
        in1    = WIDTH'($urandom);
        in2    = WIDTH'($urandom);
        approx = ED_W'($urandom);
      end
      @(posedge clk); #1;
      if (v) acc++;
      cycles++;
      if (cycles > 20 * last + 50) begin
        total++;
        bad++;
        $display("[TB] FAIL feed_timeout observed=%0d expected=%0d", acc, last);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Called one step after the last handshake edge E: done must appear exactly after E+2.
  task automatic finishRun(input string tag);
    checkOutput({tag, ".drain_ready"}, 64'(in_ready), 64'(0));
    checkOutput({tag, ".drain_busy"},  64'(busy),     64'(1));
    checkOutput({tag, ".drain_done"},  64'(done),     64'(0));
    @(posedge clk); #1;
    checkOutput({tag, ".e1_done"},     64'(done),       64'(0));
    checkOutput({tag, ".e1_cnt"},      64'(sample_cnt), 64'(qa.size() - 1));
    @(posedge clk); #1;
    checkOutput({tag, ".done"},        64'(done),     64'(1));
    checkOutput({tag, ".busy"},        64'(busy),     64'(0));
    checkOutput({tag, ".ready"},       64'(in_ready), 64'(0));
    checkStats(tag);
  endtask

  task automatic pushPair(input int a, input int b, input int x);
    qa.push_back(a);
    qb.push_back(b);
    qx.push_back(x);
  endtask

  task automatic clearQueues();
    qa.delete();
    qb.delete();
    qx.delete();
  endtask

  task automatic pushRandom(input int n);
    int a, b, ex, d;
    for (int i = 0; i < n; i++) begin
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      ex = a * b;
      case ($urandom_range(0, 2))
        0: pushPair(a, b, ex);
        1: begin
          d = $urandom_range(1, 300);
          if (ex >= d && $urandom_range(0, 1) == 1) pushPair(a, b, ex - d);
          else pushPair(a, b, ex + d);
        end
        default: pushPair(a, b, $urandom_range(0, 131071));
      endcase
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    in1         = '0;
    in2         = '0;
    approx      = '0;

    #2;
    checkZero("reset");
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    clearQueues();
    pushPair(3, 5, 15);
    doStart(1);
    checkOutput("exact.busy", 64'(busy), 64'(1));
    applyStimulus(0, 1, 1'b0);
    finishRun("exact");

    clearQueues();
    pushPair(255, 255, 65000);
    pushPair(10, 10, 110);
    pushPair(0, 7, 0);
    doStart(3);
    checkOutput("mixed.cleared", 64'(ed_max), 64'(0));
    applyStimulus(0, 3, 1'b0);
    finishRun("mixed");
    checkOutput("mixed.ed_sum_abs", 64'(ed_sum), 64'(35));

    clearQueues();
    pushPair(3, 5, 20);
    pushPair(2, 2, 4);
    doStart(2);
    applyStimulus(0, 2, 1'b0);
    in_valid = 1'b1;
    in1      = 8'd9;
    in2      = 8'd9;
    approx   = 17'd0;
    finishRun("bp");
    in_valid = 1'b0;

    doStart(0);
    checkOutput("zero.done", 64'(done), 64'(1));
    checkOutput("zero.busy", 64'(busy), 64'(0));
    clearQueues();
    checkStats("zero");

    clearQueues();
    pushRandom(3);
    doStart(3);
    checkOutput("restart.busy", 64'(busy), 64'(1));
    checkOutput("restart.done", 64'(done), 64'(0));
    applyStimulus(0, 1, 1'b0);
    start       = 1'b1;
    num_samples = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("ignored.busy", 64'(busy),       64'(1));
    checkOutput("ignored.cnt",  64'(sample_cnt), 64'(1));
    applyStimulus(1, 3, 1'b0);
    finishRun("ignored");

    for (int r = 0; r < 2; r++) begin
      clearQueues();
      pushRandom(24);
      doStart(24);
      applyStimulus(0, 24, 1'b1);
      finishRun("random");
    end

    clearQueues();
    pushRandom(5);
    doStart(5);
    applyStimulus(0, 2, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checkZero("midreset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkZero("postreset");

    clearQueues();
    pushPair(1, 1, 1);
    doStart(1);
    applyStimulus(0, 1, 1'b0);
    finishRun("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
